ascon_io_shifter: RTL and testbench

// Parametrised, share-aware I/O front-end for the Ascon AEAD core.
// - Input side: loads key, nonce, AD and PT (each SHARES-way masked) over one W-bit-per-share valid/ready port.
// - Output side: serialises CT and tag from the core back out over a W-bit valid/ready port.
// - Generalises the fixed 1-bit, always-shifting I/O with configurable lane width, share count and handshaking.

---
 rtl/ascon_io_shifter.sv | 185 ++++++++++++++++++
 tb/tb_ascon_io_shifter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_io_shifter.sv
// ascon_io_shifter
//   Share-aware I/O front-end for the Ascon AEAD core.
//   Input side: accepts key, nonce, AD and PT (SHARES-way masked) as W-bit
//   lanes per share over one valid/ready port, MSB-first into each field.
//   Output side: captures CT and tag from the core (or the dummy values on an
//   authentication failure) and streams them out LSB-first, W bits per beat.
//   Both sides run independently; clear restarts only the input side.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   clear             synchronous restart of the input side
//   in_valid/in_ready input beat handshake, in_data share s at [s*W +: W]
//   load_done         all four fields loaded
//   key_o/nonce_o/ad_o/pt_o  loaded fields, share s at [s*F +: F]
//   res_valid/res_ready      result capture handshake (res_ready = idle)
//   res_fail          select res_dummy_ct/res_dummy_tag instead of res_ct/res_tag
//   out_valid/out_ready      output beat handshake
//   out_data          current output lane
//   out_last          asserted on the final tag beat
module ascon_io_shifter #(
  parameter int K      = 128,
  parameter int L      = 80,
  parameter int Y      = 80,
  parameter int W      = 1,
  parameter int SHARES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SHARES*W-1:0]   in_data,
  output logic                  load_done,
  output logic [SHARES*K-1:0]   key_o,
  output logic [SHARES*128-1:0] nonce_o,
  output logic [SHARES*L-1:0]   ad_o,
  output logic [SHARES*Y-1:0]   pt_o,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic                  res_fail,
  input  logic [Y-1:0]          res_ct,
  input  logic [127:0]          res_tag,
  input  logic [Y-1:0]          res_dummy_ct,
  input  logic [127:0]          res_dummy_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic                  out_last
);

  localparam int KB   = K / W;
  localparam int NB   = 128 / W;
  localparam int AB   = L / W;
  localparam int PB   = Y / W;
  localparam int M1   = (KB > NB) ? KB : NB;
  localparam int M2   = (AB > PB) ? AB : PB;
  localparam int MAXB = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXB + 1);

  typedef enum logic [2:0] {S_KEY, S_NONCE, S_AD, S_PT, S_DONE} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_CT, O_TAG} out_state_t;

  in_state_t             in_state_q;
  logic [CW-1:0]         in_cnt_q;
  logic [SHARES*K-1:0]   key_q;
  logic [SHARES*128-1:0] nonce_q;
  logic [SHARES*L-1:0]   ad_q;
  logic [SHARES*Y-1:0]   pt_q;
  logic                  in_last;

  out_state_t            out_state_q;
  logic [CW-1:0]         out_cnt_q;
  logic [Y-1:0]          ct_q;
  logic [127:0]          tag_q;

  // ---------------- input side ----------------
  assign in_ready  = ~rst & (in_state_q != S_DONE);
  assign load_done = (in_state_q == S_DONE);
  assign key_o     = key_q;
  assign nonce_o   = nonce_q;
  assign ad_o      = ad_q;
  assign pt_o      = pt_q;

  always_comb begin
    in_last = 1'b0;
    case (in_state_q)
      S_KEY:   in_last = (in_cnt_q == CW'(KB - 1));
      S_NONCE: in_last = (in_cnt_q == CW'(NB - 1));
      S_AD:    in_last = (in_cnt_q == CW'(AB - 1));
      S_PT:    in_last = (in_cnt_q == CW'(PB - 1));
      default: in_last = 1'b0;
    endcase
  end

  // clear shares the reset branch, so a beat arriving with clear is dropped.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      in_state_q <= S_KEY;
      in_cnt_q   <= '0;
      key_q      <= '0;
      nonce_q    <= '0;
      ad_q       <= '0;
      pt_q       <= '0;
    end else if (in_valid && in_ready) begin
      for (int unsigned s = 0; s < SHARES; s++) begin
        case (in_state_q)
          S_KEY:   key_q[s*K +: K]       <= {key_q[s*K +: K-W], in_data[s*W +: W]};
          S_NONCE: nonce_q[s*128 +: 128] <= {nonce_q[s*128 +: 128-W], in_data[s*W +: W]};
          S_AD:    ad_q[s*L +: L]        <= {ad_q[s*L +: L-W], in_data[s*W +: W]};
          S_PT:    pt_q[s*Y +: Y]        <= {pt_q[s*Y +: Y-W], in_data[s*W +: W]};
          default: ;
        endcase
      end
      if (in_last) begin
        in_cnt_q <= '0;
        case (in_state_q)
          S_KEY:   in_state_q <= S_NONCE;
          S_NONCE: in_state_q <= S_AD;
          S_AD:    in_state_q <= S_PT;
          default: in_state_q <= S_DONE;
        endcase
      end else begin
        in_cnt_q <= in_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- output side ----------------
  assign res_ready = ~rst & (out_state_q == O_IDLE);
  assign out_valid = (out_state_q != O_IDLE);
  assign out_last  = (out_state_q == O_TAG) && (out_cnt_q == CW'(NB - 1));

  always_comb begin
    out_data = '0;
    case (out_state_q)
      O_CT:    out_data = ct_q[W-1:0];
      O_TAG:   out_data = tag_q[W-1:0];
      default: out_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_q <= O_IDLE;
      out_cnt_q   <= '0;
      ct_q        <= '0;
      tag_q       <= '0;
    end else begin
      case (out_state_q)
        O_IDLE: begin
          if (res_valid) begin
            ct_q        <= res_fail ? res_dummy_ct  : res_ct;
            tag_q       <= res_fail ? res_dummy_tag : res_tag;
            out_cnt_q   <= '0;
            out_state_q <= O_CT;
          end
        end
        O_CT: begin
          if (out_ready) begin
            ct_q <= ct_q >> W;
            if (out_cnt_q == CW'(PB - 1)) begin
              out_cnt_q   <= '0;
              out_state_q <= O_TAG;
            end else begin
              out_cnt_q <= out_cnt_q + 1'b1;
            end
          end
        end
        O_TAG: begin
          if (out_ready) begin
            tag_q <= tag_q >> W;
            if (out_cnt_q == CW'(NB - 1)) begin
              out_cnt_q   <= '0;
              out_state_q <= O_IDLE;
            end else begin
              out_cnt_q <= out_cnt_q + 1'b1;
            end
          end
        end
        default: out_state_q <= O_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_io_shifter.sv
// Testbench for ascon_io_shifter: main instance W=8/SHARES=3 checked through
// scoreboards, plus a W=1/SHARES=1 instance for a bitwise full load.
module tb_ascon_io_shifter;
  localparam int W = 8;
  localparam int S = 3;
  localparam int K = 128;
  localparam int L = 80;
  localparam int Y = 80;
  localparam int NBEAT = Y / W + 128 / W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, clear, in_valid, in_ready, load_done;
  logic [S*W-1:0]     in_data;
  logic [S*K-1:0]     key_o;
  logic [S*128-1:0]   nonce_o;
  logic [S*L-1:0]     ad_o;
  logic [S*Y-1:0]     pt_o;
  logic               res_valid, res_ready, res_fail;
  logic [Y-1:0]       res_ct, res_dummy_ct;
  logic [127:0]       res_tag, res_dummy_tag;
  logic               out_valid, out_ready, out_last;
  logic [W-1:0]       out_data;

  ascon_io_shifter #(.K(K), .L(L), .Y(Y), .W(W), .SHARES(S)) u_dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .load_done(load_done), .key_o(key_o), .nonce_o(nonce_o), .ad_o(ad_o), .pt_o(pt_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_fail(res_fail),
    .res_ct(res_ct), .res_tag(res_tag), .res_dummy_ct(res_dummy_ct), .res_dummy_tag(res_dummy_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  // Bit-serial single-share instance
  logic         in_valid1, in_ready1, load_done1, res_ready1, out_valid1, out_last1;
  logic [0:0]   in_data1, out_data1;
  logic [127:0] key1, nonce1;
  logic [79:0]  ad1, pt1;

  ascon_io_shifter #(.K(128), .L(80), .Y(80), .W(1), .SHARES(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(1'b0),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .load_done(load_done1), .key_o(key1), .nonce_o(nonce1), .ad_o(ad1), .pt_o(pt1),
    .res_valid(1'b0), .res_ready(res_ready1), .res_fail(1'b0),
    .res_ct('0), .res_tag('0), .res_dummy_ct('0), .res_dummy_tag('0),
    .out_valid(out_valid1), .out_ready(1'b0), .out_data(out_data1), .out_last(out_last1)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [S*K-1:0]   key;
    logic [S*128-1:0] nonce;
    logic [S*L-1:0]   ad;
    logic [S*Y-1:0]   pt;
  } load_t;

  load_t      load_q[$];
  logic [W:0] out_q[$];   // {last, data}

  // Reference: beat i of an n-beat field sits at lane position n-1-i (first beat in MSBs).
  task automatic do_load(input bit clr, input bit gaps, input bit det);
    load_t          e;
    logic [S*W-1:0] bq[$];
    logic [31:0]    r;
    logic [S*W-1:0] lane;
    e.key = '0; e.nonce = '0; e.ad = '0; e.pt = '0;
    for (int i = 0; i < K/W; i++) begin
      r = $urandom; lane = r[S*W-1:0];
      if (det) lane[7:0] = 8'(i);
      bq.push_back(lane);
      for (int s = 0; s < S; s++) e.key[s*K + W*(K/W-1-i) +: W] = lane[s*W +: W];
    end
    for (int i = 0; i < 128/W; i++) begin
      r = $urandom; lane = r[S*W-1:0]; bq.push_back(lane);
      for (int s = 0; s < S; s++) e.nonce[s*128 + W*(128/W-1-i) +: W] = lane[s*W +: W];
    end
    for (int i = 0; i < L/W; i++) begin
      r = $urandom; lane = r[S*W-1:0]; bq.push_back(lane);
      for (int s = 0; s < S; s++) e.ad[s*L + W*(L/W-1-i) +: W] = lane[s*W +: W];
    end
    for (int i = 0; i < Y/W; i++) begin
      r = $urandom; lane = r[S*W-1:0]; bq.push_back(lane);
      for (int s = 0; s < S; s++) e.pt[s*Y + W*(Y/W-1-i) +: W] = lane[s*W +: W];
    end
    load_q.push_back(e);
    if (clr) begin
      clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    end
    for (int k = 0; k < bq.size(); k++) begin
      if (gaps) begin
        in_valid = 1'b0; @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = bq[k];
      @(negedge clk);
      chk("in_ready_beat", in_ready, 1);
      if (k == bq.size() - 1) chk("load_done_early", load_done, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("load_done_rise", load_done, 1);
    chk("in_ready_done", in_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic garble();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom}; res_ct = t[Y-1:0];
    t = {$urandom, $urandom, $urandom, $urandom}; res_dummy_ct = t[Y-1:0];
    res_tag       = {$urandom, $urandom, $urandom, $urandom};
    res_dummy_tag = {$urandom, $urandom, $urandom, $urandom};
  endtask

  int  cyc = 0;
  int  hold_until = 0;
  bit  ready_mode = 1'b0;

  task automatic wait_ready();
    int tmo = 0;
    while (!res_ready && tmo < 1000) begin @(posedge clk); #1; tmo++; end
    chk("res_ready_wait", res_ready, 1);
  endtask

  // Capture one result and enqueue its beats: selected CT then tag, each LSB-first.
  task automatic capture(input logic [Y-1:0] ct, input logic [Y-1:0] dct,
                         input logic [127:0] tag, input logic [127:0] dtag, input bit fail);
    logic [Y-1:0]  sc;
    logic [127:0]  st;
    wait_ready();
    res_valid = 1'b1; res_fail = fail;
    res_ct = ct; res_dummy_ct = dct; res_tag = tag; res_dummy_tag = dtag;
    sc = fail ? dct : ct;
    st = fail ? dtag : tag;
    for (int i = 0; i < Y/W; i++) out_q.push_back({1'b0, sc[W*i +: W]});
    for (int i = 0; i < 128/W; i++) out_q.push_back({(i == 128/W - 1), st[W*i +: W]});
    @(posedge clk); #1;
    res_valid = 1'b0;
    garble();
  endtask

  task automatic wait_qsize(input int n);
    int tmo = 0;
    while (out_q.size() > n && tmo < 3000) begin @(posedge clk); #1; tmo++; end
  endtask

  task automatic do_res(input logic [Y-1:0] ct, input logic [Y-1:0] dct,
                        input logic [127:0] tag, input logic [127:0] dtag,
                        input bit fail, input bit spur, input int stall_at);
    logic [31:0] r;
    capture(ct, dct, tag, dtag, fail);
    if (stall_at >= 0) begin
      wait_qsize(NBEAT - stall_at);
      hold_until = cyc + 6;
    end
    if (spur) begin
      wait_qsize(10);
      chk("res_ready_busy", res_ready, 0);
      r = $urandom;
      res_valid = 1'b1; res_fail = r[0];
      @(posedge clk); #1;
      res_valid = 1'b0;
      garble();
    end
    wait_qsize(0);
    chk("out_drain", out_q.size(), 0);
  endtask

  task automatic do_res_rand(input bit fail, input bit spur, input int stall_at);
    logic [127:0] a, b;
    logic [127:0] t1, t2;
    a  = {$urandom, $urandom, $urandom, $urandom};
    b  = {$urandom, $urandom, $urandom, $urandom};
    t1 = {$urandom, $urandom, $urandom, $urandom};
    t2 = {$urandom, $urandom, $urandom, $urandom};
    do_res(a[Y-1:0], b[Y-1:0], t1, t2, fail, spur, stall_at);
  endtask

  task automatic do_load1();
    logic [127:0] ek, en;
    logic [79:0]  ea, ep;
    logic [31:0]  r;
    for (int i = 0; i < 416; i++) begin
      r = $urandom;
      if (i < 128)      ek[127 - i] = r[0];
      else if (i < 256) en[255 - i] = r[0];
      else if (i < 336) ea[335 - i] = r[0];
      else              ep[415 - i] = r[0];
      in_valid1 = 1'b1; in_data1 = r[0:0];
      @(negedge clk);
      if (i == 415) chk("w1_load_done_early", load_done1, 0);
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("w1_load_done", load_done1, 1);
    chk("w1_in_ready_done", in_ready1, 0);
    chk("w1_key", key1, ek);
    chk("w1_nonce", nonce1, en);
    chk("w1_ad", ad1, ea);
    chk("w1_pt", pt1, ep);
    @(posedge clk); #1;
  endtask

  // out_ready driver: stalls while cyc < hold_until, else random or always-ready
  initial begin
    logic [31:0] r;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      r = $urandom;
      if (cyc < hold_until) out_ready = 1'b0;
      else if (ready_mode)  out_ready = (r[1:0] != 2'b00);
      else                  out_ready = 1'b1;
    end
  end

  // Load monitor: compares fields on each rising load_done
  initial begin
    load_t e;
    logic  ld_prev;
    ld_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (load_done && !ld_prev) begin
        if (load_q.size() == 0) chk("load_unexpected", load_done, 0);
        else begin
          e = load_q.pop_front();
          chk("key", key_o, e.key);
          chk("nonce", nonce_o, e.nonce);
          chk("ad", ad_o, e.ad);
          chk("pt", pt_o, e.pt);
        end
      end
      ld_prev = load_done;
    end
  end

  // Output monitor: pops expected beat on each handshake; checks stall stability
  initial begin
    logic         stalled, h_last;
    logic [W-1:0] h_data;
    logic [W:0]   eb;
    stalled = 1'b0; h_last = 1'b0; h_data = '0;
    forever begin
      @(negedge clk);
      if (rst) stalled = 1'b0;
      else begin
        if (stalled) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, h_data);
          chk("hold_last", out_last, h_last);
        end
        stalled = out_valid && !out_ready;
        h_data  = out_data;
        h_last  = out_last;
        if (out_valid && out_ready) begin
          if (out_q.size() == 0) chk("beat_unexpected", out_valid, 0);
          else begin
            eb = out_q.pop_front();
            chk("out_data", out_data, eb[W-1:0]);
            chk("out_last", out_last, eb[W]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    in_valid1 = 1'b0; in_data1 = '0;
    res_valid = 1'b0; res_fail = 1'b0;
    garble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_ready", res_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_load_done", load_done, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_key", key_o, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_res_ready", res_ready, 1);
    chk("w1_reset_res_ready", res_ready1, 1);
    chk("w1_reset_out", {out_valid1, out_data1, out_last1}, 0);
    @(posedge clk); #1;

    // Full load, continuous valid, share0 key bytes 0x00..0x0F
    do_load(1'b1, 1'b0, 1'b1);
    chk("key_share0_bytes", key_o[127:0], 128'h000102030405060708090a0b0c0d0e0f);

    // Bit-serial single-share load
    do_load1();

    // Fixed CT/tag streamed with sink always ready
    ready_mode = 1'b0;
    do_res(80'h112233445566778899AA, 80'h0, 128'h0f0e0d0c0b0a09080706050403020100, 128'h0,
           1'b0, 1'b0, -1);

    // Forced 5-cycle stall after 7 beats
    do_res_rand(1'b0, 1'b0, 7);

    // Fail path with a spurious res_valid during the tag phase, random sink
    ready_mode = 1'b1;
    do_res_rand(1'b1, 1'b1, -1);

    // Toggling input valid running alongside output traffic
    fork
      do_load(1'b1, 1'b1, 1'b0);
      begin
        do_res_rand(1'b0, 1'b0, -1);
        do_res_rand(1'b1, 1'b0, -1);
        do_res_rand(1'b0, 1'b1, 4);
      end
    join

    // Abort a load with clear after 20 beats (clear and a beat collide), then reload
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = 24'($urandom);
      @(posedge clk); #1;
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 24'($urandom);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clear_key", key_o, 0);
    chk("clear_nonce", nonce_o, 0);
    chk("clear_load_done", load_done, 0);
    @(posedge clk); #1;
    fork
      do_load(1'b0, 1'b0, 1'b0);
      do_res_rand(1'b0, 1'b0, -1);
    join

    // rst in the middle of CT output
    ready_mode = 1'b0;
    capture(80'hA5A5A5A5A5A5A5A5A5A5, 80'h0, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A, 128'h0, 1'b0);
    wait_qsize(NBEAT - 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_q.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_res_ready", res_ready, 1);
    chk("rst_mid_out_last", out_last, 0);
    chk("rst_mid_load_done", load_done, 0);
    @(posedge clk); #1;

    // Recovery after reset
    ready_mode = 1'b1;
    fork
      do_load(1'b0, 1'b0, 1'b0);
      do_res_rand(1'b1, 1'b0, -1);
    join

    repeat (3) @(posedge clk);
    #1;
    chk("load_q_empty", load_q.size(), 0);
    chk("out_q_empty", out_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
